// File: rtl/stage_exe_pipe.sv
// rtl/stage_exe_pipe.sv - registered MIPS execute stage with handshake and iterative multiplier
module stage_exe_pipe #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_imm,
    input  logic [3:0]       control_alu_op,
    input  logic             control_use_b,
    input  logic             control_is_branch,
    input  logic             control_branch_ne,
    input  logic [WIDTH-1:0] npc,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             use_npc,
    output logic [WIDTH-1:0] jump_address
);

    localparam int N_STEPS = WIDTH / MUL_STEPS;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int SH_W    = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_use_npc;
    logic [WIDTH-1:0] r_jump;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_jump_hold;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_opb;
    logic [SH_W-1:0]  w_shamt;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu;
    logic             w_zero;
    logic             w_taken;
    logic [WIDTH-1:0] w_jump;
    logic             w_fire;
    logic             w_is_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    assign w_opb    = control_use_b ? data_b : data_imm;
    assign w_shamt  = w_opb[SH_W-1:0];
    assign w_slt    = $signed(data_a) < $signed(w_opb);
    assign w_jump   = npc + data_imm;
    assign w_is_mul = (control_alu_op == OP_MUL);
    assign w_fire   = in_valid && r_in_ready;
    assign w_last   = (r_cnt == CNT_W'(N_STEPS - 1));

    // Reserved codes and mul fall to zero here; mul results come from the accumulator.
    always_comb begin
        w_alu = '0;
        case (control_alu_op)
            OP_ADD:  w_alu = data_a + w_opb;
            OP_SUB:  w_alu = data_a - w_opb;
            OP_AND:  w_alu = data_a & w_opb;
            OP_OR:   w_alu = data_a | w_opb;
            OP_XOR:  w_alu = data_a ^ w_opb;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLL:  w_alu = data_a << w_shamt;
            OP_SRL:  w_alu = data_a >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    assign w_zero  = (w_alu == '0);
    assign w_taken = control_is_branch && (control_branch_ne ? !w_zero : w_zero);

    // One shift-add iteration: retire the low MUL_STEPS multiplier bits.
    always_comb begin
        w_acc_next = r_acc;
        for (int j = 0; j < MUL_STEPS; j++) begin
            if (r_mplier[j]) begin
                w_acc_next = w_acc_next + (r_mcand << j);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_use_npc   <= 1'b1;
            r_jump      <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_jump_hold <= '0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_fire) begin
                        if (w_is_mul) begin
                            r_state     <= S_MUL;
                            r_in_ready  <= 1'b0;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_mcand     <= data_a;
                            r_mplier    <= w_opb;
                            r_jump_hold <= w_jump;
                        end else begin
                            r_out       <= w_alu;
                            r_use_npc   <= !w_taken;
                            r_jump      <= w_jump;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_STEPS;
                    r_mplier <= r_mplier >> MUL_STEPS;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out       <= w_acc_next;
                        r_use_npc   <= 1'b1;
                        r_jump      <= r_jump_hold;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out          = r_out;
    assign use_npc      = r_use_npc;
    assign jump_address = r_jump;

endmodule

// File: tb/tb_stage_exe_pipe.sv
// tb/tb_stage_exe_pipe.sv - scoreboard bench for stage_exe_pipe at 32/1 and 16/4
module tb_stage_exe_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a, rst_b;

    logic        a_in_valid, a_in_ready, a_use_b, a_br, a_ne, a_out_valid, a_use_npc;
    logic [3:0]  a_op;
    logic [31:0] a_da, a_db, a_imm, a_npc, a_out, a_jump;

    logic        b_in_valid, b_in_ready, b_use_b, b_br, b_ne, b_out_valid, b_use_npc;
    logic [3:0]  b_op;
    logic [15:0] b_da, b_db, b_imm, b_npc, b_out, b_jump;

    stage_exe_pipe #(.WIDTH(32), .MUL_STEPS(1)) dut_a (
        .clock(clock), .reset(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_a(a_da), .data_b(a_db), .data_imm(a_imm), .control_alu_op(a_op),
        .control_use_b(a_use_b), .control_is_branch(a_br), .control_branch_ne(a_ne),
        .npc(a_npc), .out_valid(a_out_valid), .out(a_out), .use_npc(a_use_npc),
        .jump_address(a_jump)
    );

    stage_exe_pipe #(.WIDTH(16), .MUL_STEPS(4)) dut_b (
        .clock(clock), .reset(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_a(b_da), .data_b(b_db), .data_imm(b_imm), .control_alu_op(b_op),
        .control_use_b(b_use_b), .control_is_branch(b_br), .control_branch_ne(b_ne),
        .npc(b_npc), .out_valid(b_out_valid), .out(b_out), .use_npc(b_use_npc),
        .jump_address(b_jump)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        use_npc;
        logic [31:0] jump;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on w-bit values held in 32-bit containers.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic ub,
                                   input logic br, input logic ne, input logic [31:0] npc);
        exp_t e;
        logic [31:0] mask, x, y, r, sa, sb;
        int sh;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x    = a & mask;
        y    = (ub ? b : imm) & mask;
        sh   = int'(y % w);
        sa   = x << (32 - w);
        sb   = y << (32 - w);
        case (op)
            4'd0:    r = x + y;
            4'd1:    r = x - y;
            4'd2:    r = x & y;
            4'd3:    r = x | y;
            4'd4:    r = x ^ y;
            4'd5:    r = ($signed(sa) < $signed(sb)) ? 32'd1 : 32'd0;
            4'd6:    r = x << sh;
            4'd7:    r = x >> sh;
            4'd8:    r = x * y;
            default: r = 32'd0;
        endcase
        r = r & mask;
        e.res     = r;
        e.use_npc = (op == 4'd8) ? 1'b1 : !(br && (ne ? (r != 0) : (r == 0)));
        e.jump    = (npc + imm) & mask;
        return e;
    endfunction

    // Called at a falling edge; returns at a falling edge after acceptance.
    task automatic drive(input bit sel, input logic [3:0] op, input logic [31:0] da,
                         input logic [31:0] db, input logic [31:0] imm, input logic ub,
                         input logic br, input logic ne, input logic [31:0] npc,
                         input bit push, output int waited);
        waited = 0;
        if (!sel) begin
            a_op = op; a_da = da; a_db = db; a_imm = imm; a_use_b = ub;
            a_br = br; a_ne = ne; a_npc = npc; a_in_valid = 1'b1;
        end else begin
            b_op = op; b_da = da[15:0]; b_db = db[15:0]; b_imm = imm[15:0]; b_use_b = ub;
            b_br = br; b_ne = ne; b_npc = npc[15:0]; b_in_valid = 1'b1;
        end
        while ((sel ? b_in_ready : a_in_ready) !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: dut %0d in_ready stayed %b, required 1", sel,
                     sel ? b_in_ready : a_in_ready);
            a_in_valid = 1'b0;
            b_in_valid = 1'b0;
        end else begin
            if (push) begin
                if (!sel) qa.push_back(model(32, op, da, db, imm, ub, br, ne, npc));
                else      qb.push_back(model(16, op, {16'b0, da[15:0]}, {16'b0, db[15:0]},
                                             {16'b0, imm[15:0]}, ub, br, ne, {16'b0, npc[15:0]}));
            end
            @(posedge clock);
            @(negedge clock);
            if (!sel) a_in_valid = 1'b0;
            else      b_in_valid = 1'b0;
            if (op != 4'd8)
                chk(sel ? "b_latency_valid" : "a_latency_valid",
                    {31'b0, sel ? b_out_valid : a_out_valid}, 32'd1);
        end
    endtask

    always @(negedge clock) begin
        if (a_out_valid === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected_valid: out_valid 1 with out=%h, required no result", a_out);
            end else begin
                ea = qa.pop_front();
                chk("a_out", a_out, ea.res);
                chk("a_use_npc", {31'b0, a_use_npc}, {31'b0, ea.use_npc});
                chk("a_jump", a_jump, ea.jump);
            end
        end
    end

    always @(negedge clock) begin
        if (b_out_valid === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected_valid: out_valid 1 with out=%h, required no result", b_out);
            end else begin
                eb = qb.pop_front();
                chk("b_out", {16'b0, b_out}, eb.res);
                chk("b_use_npc", {31'b0, b_use_npc}, {31'b0, eb.use_npc});
                chk("b_jump", {16'b0, b_jump}, eb.jump);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int w;
        logic [3:0] op;
        logic [31:0] ra, rb;
        rst_a = 1'b0; rst_b = 1'b0;
        a_in_valid = 0; a_op = 0; a_da = 0; a_db = 0; a_imm = 0; a_use_b = 0; a_br = 0; a_ne = 0; a_npc = 0;
        b_in_valid = 0; b_op = 0; b_da = 0; b_db = 0; b_imm = 0; b_use_b = 0; b_br = 0; b_ne = 0; b_npc = 0;
        repeat (2) @(negedge clock);
        chk("a_rst_out", a_out, 32'd0);
        chk("a_rst_use_npc", {31'b0, a_use_npc}, 32'd1);
        chk("a_rst_jump", a_jump, 32'd0);
        chk("a_rst_valid", {31'b0, a_out_valid}, 32'd0);
        chk("a_rst_ready", {31'b0, a_in_ready}, 32'd0);
        chk("b_rst_ready", {31'b0, b_in_ready}, 32'd0);
        chk("b_rst_use_npc", {31'b0, b_use_npc}, 32'd1);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clock);
        chk("a_ready_after_rst", {31'b0, a_in_ready}, 32'd1);
        chk("b_ready_after_rst", {31'b0, b_in_ready}, 32'd1);

        drive(0, 4'd0, 3, 2, 1, 1, 0, 0, 0, 1, w);
        chk("a_add_out", a_out, 32'd5);
        chk("a_add_jump", a_jump, 32'd1);
        drive(0, 4'd0, 3, 2, 1, 0, 0, 0, 1, 1, w);
        chk("a_addi_out", a_out, 32'd4);
        chk("a_addi_jump", a_jump, 32'd2);
        drive(0, 4'd1, 2, 2, 7, 1, 1, 0, 5, 1, w);
        chk("a_beq_use_npc", {31'b0, a_use_npc}, 32'd0);
        chk("a_beq_jump", a_jump, 32'd12);
        drive(0, 4'd1, 2, 2, 7, 1, 1, 1, 5, 1, w);
        chk("a_bne_use_npc", {31'b0, a_use_npc}, 32'd1);
        drive(0, 4'd1, 2, 2, 7, 1, 0, 0, 6, 1, w);
        chk("a_nobr_jump", a_jump, 32'd13);

        drive(0, 4'd8, 7, 6, 0, 1, 0, 0, 0, 1, w);
        drive(0, 4'd0, 1, 1, 0, 1, 0, 0, 0, 1, w);
        chk("a_mul_stall_cycles", w, 32);

        drive(0, 4'd0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 1, w);
        chk("a_wrap_add", a_out, 32'd0);
        drive(0, 4'd0, 0, 0, 8, 1, 0, 0, 32'hFFFF_FFFC, 1, w);
        chk("a_wrap_jump", a_jump, 32'd4);
        drive(0, 4'd5, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 1, w);
        chk("a_slt_neg", a_out, 32'd1);
        drive(0, 4'd7, 32'h8000_0000, 33, 0, 1, 0, 0, 0, 1, w);
        chk("a_srl_33", a_out, 32'h4000_0000);
        drive(0, 4'd12, 5, 6, 0, 1, 0, 0, 0, 1, w);
        chk("a_reserved", a_out, 32'd0);

        drive(0, 4'd8, 5, 9, 0, 1, 0, 0, 0, 0, w);
        repeat (9) @(negedge clock);
        rst_a = 1'b0;
        #1;
        chk("a_midrst_out", a_out, 32'd0);
        chk("a_midrst_use_npc", {31'b0, a_use_npc}, 32'd1);
        chk("a_midrst_jump", a_jump, 32'd0);
        chk("a_midrst_ready", {31'b0, a_in_ready}, 32'd0);
        repeat (3) @(negedge clock);
        rst_a = 1'b1;
        @(negedge clock);
        chk("a_ready_after_midrst", {31'b0, a_in_ready}, 32'd1);
        drive(0, 4'd0, 10, 20, 0, 1, 0, 0, 0, 1, w);
        chk("a_add_after_midrst", a_out, 32'd30);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8 && ($urandom % 4) != 0) op = 4'd0;
            ra = $urandom;
            rb = (($urandom % 4) == 0) ? ra : $urandom;
            drive(0, op, ra, rb, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1, w);
        end

        drive(1, 4'd8, 300, 300, 0, 1, 0, 0, 0, 1, w);
        repeat (3) @(negedge clock);
        chk("b_mul_not_early", {31'b0, b_out_valid}, 32'd0);
        @(negedge clock);
        chk("b_mul_valid_at_4", {31'b0, b_out_valid}, 32'd1);
        chk("b_mul_out", {16'b0, b_out}, 32'h5F90);
        chk("b_ready_after_mul", {31'b0, b_in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'd0, i, 100, 0, 1, 0, 0, i, 1, w);
            chk("b_stream_no_wait", w, 0);
        end
        for (int i = 0; i < 100; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (($urandom % 4) == 0) ? ra : $urandom;
            drive(1, op, ra, rb, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1, w);
        end

        repeat (50) @(negedge clock);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stage_exe_pipe.md
# stage_exe_pipe

Parametrised, registered execute stage for the MIPS pipeline. It replaces the purely combinational execute path. It evaluates the ALU operation on operand A and either operand B or the immediate, resolves BEQ/BNE branches, and computes the branch target `npc + imm`. It adds a valid/ready handshake and an iterative multi-cycle multiplier that stalls the issue stage while busy. Results are registered toward the EX/MEM boundary.

## Interface
Parameters:
- WIDTH, 32, datapath width for operands, result, npc and jump address
- MUL_STEPS, 1, multiplier bits retired per cycle; must divide WIDTH

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  issue stage presents an operation
- in_ready  out  1  stage can accept an operation this cycle
- data_a  in  WIDTH  operand A
- data_b  in  WIDTH  operand B
- data_imm  in  WIDTH  sign-extended immediate
- control_alu_op  in  4  operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed), 6 sll, 7 srl, 8 mul; 9-15 reserved
- control_use_b  in  1  1 selects data_b as second operand, 0 selects data_imm
- control_is_branch  in  1  operation is a conditional branch
- control_branch_ne  in  1  0 = BEQ, 1 = BNE (meaningful only with is_branch)
- npc  in  WIDTH  next sequential PC
- out_valid  out  1  one-cycle pulse: the registered outputs hold a new result
- out  out  WIDTH  registered ALU/multiplier result
- use_npc  out  1  1 = continue at npc; 0 = branch taken, fetch jump_address
- jump_address  out  WIDTH  registered npc + data_imm

## Operation
- Operand select: `opb = control_use_b ? data_b : data_imm`.
- Arithmetic is modulo 2^WIDTH.
- slt compares signed and yields 1 or 0.
- sll and srl shift by `opb[$clog2(WIDTH)-1:0]`; srl is logical.
- mul yields the low WIDTH bits of `data_a * opb`.
- Reserved op codes yield out = 0.
- Branch resolution: zero = (result == 0), taken = is_branch & (branch_ne ? !zero : zero), and use_npc = !taken. A mul op always produces use_npc = 1.
- jump_address = npc + data_imm, wrapping, and is captured with every accepted operation.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, a non-mul op has all outputs registered at that edge and out_valid = 1 next cycle, staying in IDLE. A mul op latches data_a, opb and npc + imm, clears the accumulator and counter, and moves to MUL.
  - MUL: in_ready = 0. Each cycle processes MUL_STEPS multiplier bits by shift-add. After WIDTH/MUL_STEPS cycles it registers out, use_npc = 1 and jump_address, pulses out_valid, and returns to IDLE.
- in_valid while in_ready = 0 is ignored. Upstream must hold its operation until it is accepted.
- There is no downstream backpressure. out/use_npc/jump_address hold their value until the next result is registered.

## Timing
- Reset asserted: state goes to IDLE, out = 0, use_npc = 1, jump_address = 0, out_valid = 0, and in_ready = 0.
- in_ready rises in the first cycle after reset deasserts.
- Reset during MUL aborts the multiplication with no out_valid. Partial products are discarded.
- Non-mul op accepted at edge k: results are visible and out_valid = 1 in cycle k..k+1. Throughput is one op per cycle.
- Mul op accepted at edge k: in_ready = 0 from edge k to edge k+N, where N = WIDTH/MUL_STEPS. The result and the out_valid pulse appear after edge k+N. in_ready = 1 in that same cycle, so the next op can be accepted at edge k+N+1.
- out_valid is never high for two consecutive cycles from the same operation.

## Test plan
- Add, then immediate-add (WIDTH=32):
  - a=3, b=2, imm=1, op add, use_b=1, npc=0 → out=5, use_npc=1, jump_address=1, out_valid one cycle after accept.
  - Same operands with use_b=0, npc=1 → out=4, jump_address=2.
- Branches:
  - a=2, b=2, imm=7, sub, is_branch=1, branch_ne=0, npc=5 → out=0, use_npc=0, jump_address=12.
  - Same with branch_ne=1 → use_npc=1.
  - Same with is_branch=0, npc=6 → use_npc=1, jump_address=13.
- Multiply and stall:
  - a=7, b=6, mul → in_ready low for 32 cycles, then out=42 with an out_valid pulse.
  - An add held on in_valid during the stall is accepted only on the first cycle after in_ready returns.
- Wrap and edge cases:
  - 0xFFFFFFFF + 1 → 0.
  - npc=0xFFFFFFFC, imm=8 → jump_address=4.
  - slt -1 < 1 → 1.
  - srl 0x80000000 by 33 → 0x40000000.
  - Op 12 → out=0.
- Reset mid-multiply: assert reset 10 cycles into a mul → all outputs at reset values and no out_valid. After release, in_ready=1 and a new add completes normally.
- Parametrised instance (WIDTH=16, MUL_STEPS=4):
  - Mul latency is 4 cycles; 300*300 → 0x5F90.
  - Back-to-back adds stream at one per cycle with an out_valid pulse every cycle.
